// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: shares one cache-line bus to memory among NUM_INPUTS
// cache-side requesters. One requester owns the bus from grant until its
// final beat (ready && last). Ownership then rotates to the requester after
// the previous owner. Requests pass through to memory combinationally, and
// responses return combinationally to the owner only.

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0]   ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]   iresps,
    output cbus_req_t                     oreq,
    input  cbus_resp_t                    oresp
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    if (NUM_INPUTS < 2 || NUM_INPUTS > 8) begin : g_bad_num_inputs
        $error("cbus_rr_arbiter: NUM_INPUTS must be in the range 2..8");
    end

    state_t state;
    state_t state_nxt;
    idx_t   index;
    idx_t   index_nxt;
    idx_t   ptr;
    idx_t   ptr_nxt;
    idx_t   index_inc;
    idx_t   scan_idx;
    logic   scan_hit;

    // Successor of the current owner, wrapping explicitly so that
    // non-power-of-two requester counts return to 0 after NUM_INPUTS-1.
    assign index_inc = (index == idx_t'(NUM_INPUTS - 1)) ? '0 : index + idx_t'(1);

    // Find the first valid requester at or after ptr, modulo NUM_INPUTS.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = ptr;
        for (int o = 0; o < NUM_INPUTS; o++) begin
            int   c;
            idx_t cidx;
            c = int'(ptr) + o;
            if (c >= NUM_INPUTS) begin
                c = c - NUM_INPUTS;
            end
            cidx = idx_t'(c);
            if (!scan_hit && ireqs[cidx].valid) begin
                scan_hit = 1'b1;
                scan_idx = cidx;
            end
        end
    end

    // Next-state logic: grant from IDLE, and release only on the final beat.
    always_comb begin
        state_nxt = state;
        index_nxt = index;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (scan_hit) begin
                    state_nxt = BUSY;
                    index_nxt = scan_idx;
                end
            end
            BUSY: begin
                // The owner keeps the bus even if its valid drops; only the
                // final beat releases it.
                if (oresp.ready && oresp.last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = index_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output routing: the owner's request goes to memory, and the memory
    // response goes to the owner. Everything else is zero. oreq depends only
    // on registered state and ireqs.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state == BUSY) begin
            oreq          = ireqs[index];
            iresps[index] = oresp;
        end
    end

    // State, owner and round-robin pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            index <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule
